// File: rtl/seq_magnitude_mult.sv
// Sequential shift-add multiplier for sign-magnitude operands. Produces the exact product
// and a FRAC-scaled, saturated magnitude one result every SIZE+1 cycles.
module seq_magnitude_mult #(
    parameter int unsigned SIZE = 8,
    parameter int unsigned FRAC = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [SIZE-1:0]   a_i,
    input  logic              sign_a_i,
    input  logic [SIZE-1:0]   w_i,
    input  logic              sign_w_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [SIZE-1:0]   p_o,
    output logic              sign_p_o,
    output logic              ovf_o,
    output logic [2*SIZE-1:0] p_full_o
);

    localparam int unsigned W2   = 2 * SIZE;
    localparam int unsigned CntW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(SIZE - 1);
    localparam logic [W2-1:0]   MaxMag  = W2'((1 << (SIZE - 1)) - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [W2-1:0]   mcand_q, acc_q, p_full_q;
    logic [SIZE-1:0] mplier_q, p_q;
    logic [CntW-1:0] cnt_q;
    logic            sign_q, sign_p_q, ovf_q;

    logic            accept, last;
    logic [W2-1:0]   acc_sum, q_scaled;
    logic            sat;
    logic [SIZE-1:0] p_res;
    logic            sign_res;

    assign accept = start_i && (state_q != StRun);
    assign last   = (state_q == StRun) && (cnt_q == LastCnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = start_i ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = (state_q == StRun);
        done_o = (state_q == StDone);
    end

    // The final iteration's sum feeds the output registers directly, saving a cycle.
    always_comb begin
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        q_scaled = acc_sum >> FRAC;
        sat      = (q_scaled > MaxMag);
        p_res    = sat ? MaxMag[SIZE-1:0] : q_scaled[SIZE-1:0];
        sign_res = sign_q & (p_res != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            p_full_q <= '0;
            p_q      <= '0;
            sign_p_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            mcand_q  <= {{SIZE{1'b0}}, a_i};
            mplier_q <= w_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= sign_a_i ^ sign_w_i;
        end else if (state_q == StRun) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CntW'(1);
            if (last) begin
                p_full_q <= acc_sum;
                p_q      <= p_res;
                sign_p_q <= sign_res;
                ovf_q    <= sat;
            end
        end
    end

    assign p_o      = p_q;
    assign sign_p_o = sign_p_q;
    assign ovf_o    = ovf_q;
    assign p_full_o = p_full_q;

endmodule

// File: tb/tb_seq_magnitude_mult.sv
// Scoreboard bench for seq_magnitude_mult: a driver queues arithmetic expectations, a negedge
// monitor checks every done pulse against them.
module tb_seq_magnitude_mult;

    localparam int unsigned SIZE = 8;
    localparam int unsigned FRAC = 6;
    localparam int          LAT  = SIZE + 1;

    typedef struct {
        logic [2*SIZE-1:0] full;
        logic [SIZE-1:0]   p;
        logic              s;
        logic              ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [SIZE-1:0]   a_i = '0;
    logic              sign_a_i = 1'b0;
    logic [SIZE-1:0]   w_i = '0;
    logic              sign_w_i = 1'b0;
    logic              busy_o, done_o, sign_p_o, ovf_o;
    logic [SIZE-1:0]   p_o;
    logic [2*SIZE-1:0] p_full_o;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    seq_magnitude_mult #(.SIZE(SIZE), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .a_i      (a_i),
        .sign_a_i (sign_a_i),
        .w_i      (w_i),
        .sign_w_i (sign_w_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .p_o      (p_o),
        .sign_p_o (sign_p_o),
        .ovf_o    (ovf_o),
        .p_full_o (p_full_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t model(input int a, input bit sa, input int w, input bit sw);
        exp_t e;
        int   full, q, maxmag;
        full   = a * w;
        q      = full / (1 << FRAC);
        maxmag = (1 << (SIZE - 1)) - 1;
        e.full = full[2*SIZE-1:0];
        e.ovf  = (q > maxmag);
        e.p    = e.ovf ? maxmag[SIZE-1:0] : q[SIZE-1:0];
        e.s    = (sa ^ sw) && (e.p != 0);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("p_full", p_full_o, e.full);
                check("p", p_o, e.p);
                check("sign_p", sign_p_o, e.s);
                check("ovf", ovf_o, e.ovf);
                check("busy_at_done", busy_o, 0);
            end
        end
    end

    task automatic drive(input int a, input bit sa, input int w, input bit sw);
        a_i      = a[SIZE-1:0];
        sign_a_i = sa;
        w_i      = w[SIZE-1:0];
        sign_w_i = sw;
        exp_q.push_back(model(a, sa, w, sw));
    endtask

    // Counts negedges from the one where start was raised until done is seen.
    task automatic wait_done(input int limit, inout int lat);
        while (!done_o && lat < limit) begin
            @(negedge clk);
            lat++;
        end
        if (!done_o) check("done_timeout", lat, LAT);
    endtask

    task automatic do_op(input int a, input bit sa, input int w, input bit sw,
                         input bit inject);
        int lat;
        @(negedge clk);
        drive(a, sa, w, sw);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        if (inject) begin
            repeat (2) begin
                @(negedge clk);
                lat++;
            end
            // Stray start mid-run with different operands must be ignored.
            a_i = 8'h7F; w_i = 8'h7F; sign_a_i = ~sa; start_i = 1'b1;
            @(negedge clk);
            lat++;
            start_i = 1'b0;
        end
        wait_done(40, lat);
        check("latency", lat, LAT);
    endtask

    initial begin
        int lat;
        int gap;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_p", p_o, 0);
        check("rst_sign_p", sign_p_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_p_full", p_full_o, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'h40, 0, 8'h40, 1, 0);
        do_op(8'h80, 1, 8'h80, 1, 0);
        do_op(8'h00, 1, 8'h25, 0, 0);
        do_op(8'h03, 0, 8'h15, 0, 0);
        do_op(8'h7F, 0, 8'h7F, 0, 0);
        do_op(8'h11, 1, 8'h22, 0, 1);

        for (int i = 0; i < 20; i++) begin
            do_op($urandom_range(128), 1'($urandom), $urandom_range(128), 1'($urandom), 0);
        end

        // Back-to-back: start held high, new operands presented at each done.
        @(negedge clk);
        drive($urandom_range(128), 1'($urandom), $urandom_range(128), 1'($urandom));
        start_i = 1'b1;
        lat = 0;
        wait_done(40, lat);
        for (int k = 0; k < 3; k++) begin
            drive($urandom_range(128), 1'($urandom), $urandom_range(128), 1'($urandom));
            @(negedge clk);
            gap = 1;
            if (k == 2) start_i = 1'b0;
            wait_done(40, gap);
            check("b2b_period", gap, LAT);
        end

        // Reset mid-run after a result with nonzero outputs.
        do_op(8'h80, 1, 8'h80, 0, 0);
        @(negedge clk);
        a_i = 8'h55; w_i = 8'h66; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_p", p_o, 0);
        check("midrst_ovf", ovf_o, 0);
        check("midrst_sign_p", sign_p_o, 0);
        check("midrst_p_full", p_full_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        do_op(8'h20, 0, 8'h40, 0, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
